btn_debounce: RTL and testbench
===============================

# btn_debounce

Conditions the three raw FPGA push-buttons (up, down, centre/reset) into clean, glitch-free, single-cycle command pulses for the game-play logic. Sits directly between the board pins and the game-play core, in the top-level clock domain. Each button gets a two-flop synchronizer, a counter-based debouncer and a press-edge detector. Conflicting up/down presses are arbitrated.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1000000, cycles a synchronized input must differ from the debounced level before the level flips (10 ms at 100 MHz); legal ≥ 2.
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- REPEAT_DELAY, 50000000, hold cycles before the first auto-repeat pulse (used only with BTN_AUTOREPEAT_EN).
- REPEAT_PERIOD, 20000000, cycles between subsequent auto-repeat pulses (used only with BTN_AUTOREPEAT_EN).

Ports:
- clk  in  1  system clock, 100 MHz; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset; asserting clears all state immediately, deassertion is synchronous to clk.
- btnU  in  1  raw up button, asynchronous, active-high.
- btnD  in  1  raw down button, asynchronous, active-high.
- btnS  in  1  raw centre button, asynchronous, active-high.
- up  out  1  one-cycle pulse per accepted up press.
- down  out  1  one-cycle pulse per accepted down press.
- reset  out  1  one-cycle pulse per accepted centre press; this is the game's soft reset request.
- level  out  3  debounced levels {S, D, U}.

## Operation
- Synchronizer: two flops per button (sync1, sync2). Reset value is 0.
- Debouncer, per button: `stable` reg and CNT_W-bit `cnt`.
  - If sync2 == stable, then cnt <= 0.
  - Otherwise, if cnt == DEBOUNCE_CYCLES-1, then stable <= sync2 and cnt <= 0.
  - Otherwise, cnt <= cnt+1.
  - A bounce back to the stable value before terminal count restarts the count from 0.
- Press detect: a candidate pulse fires on the edge where `stable` goes 0→1. Release (1→0) produces no pulse.
- Arbitration: if up and down candidates fire on the same edge, both are suppressed. `reset` is never suppressed and is independent of U/D.
- Outputs up, down and reset are registered and high for exactly one cycle. `level` = the stable regs.
- Reset values: up=0, down=0, reset=0, level=3'b000. All cnt=0, all sync flops 0, repeat counters 0.
- If reset_n is asserted mid-count, the count is discarded. After release, a held button is seen as a fresh 0→1 press once it has debounced.

## Timing
- Latency: raw input changes before clock edge 0 and holds. sync2 changes at edge 1. `stable` and the output pulse change at edge 1+DEBOUNCE_CYCLES. The pulse is high for the following cycle only.
- Minimum press width for acceptance: DEBOUNCE_CYCLES cycles of stable synchronized level.
- No output depends combinationally on any input.
- The first-stage synchronizer flop is the only crossing point. No raw input may feed other logic.

## Configuration
- BTN_AUTOREPEAT_EN defined:
  - While up or down stays held after its press pulse, a repeat counter runs.
  - The first repeat pulse comes REPEAT_DELAY cycles after the press pulse; further pulses follow every REPEAT_PERIOD cycles.
  - Release, or the other direction button also held, stops repeats and clears the counter.
  - Repeat pulses obey the same up/down suppression rule.
  - `reset` never repeats.
- Not defined: exactly one pulse per press. No repeat counters or parameters are used; they must synthesize away.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, CNT_W=3, REPEAT_DELAY=10, REPEAT_PERIOD=3.
- Clean press: btnU 0→1 before edge 0, held 20 cycles → up high for one cycle after edge 5; level[0]=1 from edge 5; no further up pulse; down=reset=0 throughout.
- Bounce: btnD toggles 1,0,1,0 at 2-cycle intervals, then held 1 → no pulse during the bounce; down pulses once, 5 edges after the final 0→1 transition.
- Simultaneous conflict: btnU and btnD rise together → level=3'b011 at edge 5, up=down=0 always; then btnS press → reset pulses once.
- Reset mid-operation: btnU rises, reset_n pulsed low at edge 3 for 2 cycles, btnU held → outputs 0 immediately at assertion; up pulses once, 5 edges after reset_n deassertion.
- Release and short glitch: hold btnS, release → no pulse on release; a 3-cycle btnS glitch → no reset pulse, level[2] stays 0.
- Auto-repeat (BTN_AUTOREPEAT_EN defined): btnU held 30 cycles → up pulses at press, press+10, press+13, press+16…; with the macro undefined → single pulse only.

Source files
------------

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop sync, counter debounce and press-edge pulse per button,
// with up/down conflict suppression. Define BTN_AUTOREPEAT_EN to add hold-to-repeat on up/down.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 20000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btnU,
    input  logic       btnD,
    input  logic       btnS,
    output logic       up,
    output logic       down,
    output logic       reset,
    output logic [2:0] level
);
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES >= (2 ** CNT_W)) begin : g_bad_debounce_cfg
        $error("btn_debounce: need DEBOUNCE_CYCLES >= 2 and 2**CNT_W > DEBOUNCE_CYCLES");
    end
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat_cfg
        $error("btn_debounce: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit order everywhere is {S, D, U}.
    logic [2:0] btn_raw;
    logic [2:0] sync1_q, sync2_q;
    logic [2:0] stable_q, stable_d;
    logic [2:0] cand;
    logic [1:0] rpt;
    logic       fire_u, fire_d;

    assign btn_raw = {btnS, btnD, btnU};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    for (genvar b = 0; b < 3; b++) begin : g_deb
        logic [CNT_W-1:0] cnt_q;
        logic             differ;

        assign differ      = sync2_q[b] ^ stable_q[b];
        assign stable_d[b] = (differ && cnt_q == CNT_TERM) ? sync2_q[b] : stable_q[b];

        // Any return to the stable level restarts the qualification window.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                cnt_q <= '0;
            else if (!differ || cnt_q == CNT_TERM)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stable_q <= '0;
        else
            stable_q <= stable_d;
    end

    assign cand = stable_d & ~stable_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DLY_TERM = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_TERM = RPT_W'(REPEAT_PERIOD - 1);

    for (genvar k = 0; k < 2; k++) begin : g_rpt
        logic [RPT_W-1:0] rcnt_q;
        logic             first_q, armed_q, hold;

        assign hold   = stable_q[k] & ~stable_q[1-k];
        assign rpt[k] = armed_q & hold & (rcnt_q == (first_q ? DLY_TERM : PER_TERM));

        // Armed only by a fresh press; a broken hold waits for the next press.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rcnt_q  <= '0;
                first_q <= 1'b0;
                armed_q <= 1'b0;
            end else if (cand[k]) begin
                rcnt_q  <= '0;
                first_q <= 1'b1;
                armed_q <= 1'b1;
            end else if (!(armed_q && hold)) begin
                rcnt_q  <= '0;
                armed_q <= 1'b0;
            end else if (rpt[k]) begin
                rcnt_q  <= '0;
                first_q <= 1'b0;
            end else begin
                rcnt_q  <= rcnt_q + 1'b1;
            end
        end
    end
`else
    assign rpt = 2'b00;
`endif

    assign fire_u = cand[0] | rpt[0];
    assign fire_d = cand[1] | rpt[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            up    <= 1'b0;
            down  <= 1'b0;
            reset <= 1'b0;
        end else begin
            up    <= fire_u & ~fire_d;
            down  <= fire_d & ~fire_u;
            reset <= cand[2];
        end
    end

    assign level = stable_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce: a window-based reference model predicts every cycle's
// outputs into a queue; a negedge monitor pops and compares.
module tb_btn_debounce;
    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btnU = 1'b0, btnD = 1'b0, btnS = 1'b0;
    logic       up, down, reset;
    logic [2:0] level;

    int checks   = 0;
    int failures = 0;

    btn_debounce #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .btnU(btnU), .btnD(btnD), .btnS(btnS),
        .up(up), .down(down), .reset(reset), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       u;
        logic       d;
        logic       s;
        logic [2:0] lvl;
    } exp_t;

    exp_t expq[$];

    // Reference state: raw samples still in flight through the 2-cycle synchronizer,
    // the last D synchronized values, and the accepted levels.
    bit rawd [3][2];
    bit seen [3][D];
    bit stab [3];
    bit armed [2];
    int age [2];

    task automatic model_clear();
        for (int b = 0; b < 3; b++) begin
            rawd[b][0] = 1'b0; rawd[b][1] = 1'b0; stab[b] = 1'b0;
            for (int i = 0; i < D; i++) seen[b][i] = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin armed[k] = 1'b0; age[k] = 0; end
    endtask

    task automatic model_step();
        bit   raw [3];
        bit   ns [3];
        bit   cand [3];
        bit   rep [2];
        bit   s, all_differ, uf, df;
        exp_t e;
        raw[0] = btnU; raw[1] = btnD; raw[2] = btnS;
        for (int b = 0; b < 3; b++) begin
            s = rawd[b][1];
            rawd[b][1] = rawd[b][0];
            rawd[b][0] = raw[b];
            for (int i = D - 1; i > 0; i--) seen[b][i] = seen[b][i-1];
            seen[b][0] = s;
            // Level flips once the last D synchronized samples all disagree with it.
            all_differ = 1'b1;
            for (int i = 0; i < D; i++) if (seen[b][i] == stab[b]) all_differ = 1'b0;
            ns[b]   = all_differ ? ~stab[b] : stab[b];
            cand[b] = ns[b] & ~stab[b];
        end
        for (int k = 0; k < 2; k++) begin
            rep[k] = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            if (cand[k]) begin
                armed[k] = 1'b1; age[k] = 0;
            end else if (armed[k] && stab[k] && !stab[1-k]) begin
                age[k]++;
                rep[k] = (age[k] == RD) || (age[k] > RD && (age[k] - RD) % RP == 0);
            end else begin
                armed[k] = 1'b0;
            end
`endif
        end
        for (int b = 0; b < 3; b++) stab[b] = ns[b];
        uf = cand[0] | rep[0];
        df = cand[1] | rep[1];
        e.u   = uf & ~df;
        e.d   = df & ~uf;
        e.s   = cand[2];
        e.lvl = {stab[2], stab[1], stab[0]};
        expq.push_back(e);
    endtask

    initial model_clear();
    always @(negedge reset_n) model_clear();

    always @(posedge clk) begin
        if (!reset_n) begin
            model_clear();
            expq.push_back('0);
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            if ({up, down, reset, level} !== e) begin
                failures++;
                $display("FAIL outputs t=%0t got up=%b down=%b reset=%b level=%b want up=%b down=%b reset=%b level=%b",
                         $time, up, down, reset, level, e.u, e.d, e.s, e.lvl);
            end
        end
    end

    task automatic drive(input logic u, input logic d, input logic s, input int n);
        @(negedge clk);
        btnU = u; btnD = d; btnS = s;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({up, down, reset, level} !== 6'b0) begin
            failures++;
            $display("FAIL async_reset got %b want 000000", {up, down, reset, level});
        end
        repeat (n) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bit cur [3];
        int rem [3];
        repeat (3) @(negedge clk);
        checks++;
        if ({up, down, reset, level} !== 6'b0) begin
            failures++;
            $display("FAIL reset_state got %b want 000000", {up, down, reset, level});
        end
        reset_n = 1'b1;

        drive(1, 0, 0, 20); drive(0, 0, 0, 10);            // clean press
        drive(0, 1, 0, 2);  drive(0, 0, 0, 2);              // bounce
        drive(0, 1, 0, 2);  drive(0, 0, 0, 2);
        drive(0, 1, 0, 12); drive(0, 0, 0, 10);
        drive(1, 1, 0, 15); drive(0, 0, 0, 10);            // conflict
        drive(0, 0, 1, 10); drive(0, 0, 0, 10);
        drive(1, 0, 0, 3);  pulse_reset(2);                 // reset mid-count
        drive(1, 0, 0, 12); drive(0, 0, 0, 10);
        drive(0, 0, 1, 3);  drive(0, 0, 0, 10);            // glitch one short of acceptance
        drive(0, 0, 1, 4);  drive(0, 0, 0, 10);            // exactly long enough
        drive(1, 0, 0, 30); drive(0, 0, 0, 10);            // hold for repeat
        drive(0, 1, 0, 30); drive(1, 1, 0, 15);            // second direction joins mid-hold
        drive(0, 1, 0, 20); drive(0, 0, 0, 10);

        for (int b = 0; b < 3; b++) begin cur[b] = 1'b0; rem[b] = 0; end
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (rem[b] == 0) begin
                    cur[b] = ~cur[b];
                    rem[b] = ($urandom_range(0, 4) == 0) ? $urandom_range(18, 35) : $urandom_range(1, 7);
                end
                rem[b]--;
            end
            if ($urandom_range(0, 199) == 0) pulse_reset($urandom_range(1, 3));
            drive(cur[0], cur[1], cur[2], 1);
        end

        drive(0, 0, 0, 20);
        checks++;
        if (expq.size() > 1) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending want <=1", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
